// File: rtl/ps2_tx.sv
// ps2_tx
// Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED
// set-LEDs or 0xFF reset) to a keyboard over the shared open-drain PS/2 lines.
// It handles the request-to-send, device-clocked bit shifting, odd parity,
// the stop bit and ACK sampling. While busy is high, the companion receiver's
// input should be disregarded.
//
// Ports:
//   clk         system clock (50 MHz nominal)
//   rst         asynchronous reset, active low
//   ps2ClkIn    raw PS/2 clock pad input
//   ps2DataIn   raw PS/2 data pad input
//   ps2ClkOe    1 = pull PS/2 clock low, 0 = release
//   ps2DataOe   1 = pull PS/2 data low, 0 = release
//   txData      command byte, captured when txStart is accepted
//   txStart     single-cycle send request, ignored while busy
//   busy        transfer in progress
//   done        one-cycle pulse when the frame finishes (ACK or NACK)
//   ackErr      one-cycle pulse alongside done when the device did not ACK
//   timeoutErr  one-cycle pulse when the frame is aborted by the timeout
//
// INHIBIT_CYCLES must be at least 2 so that the start bit can be asserted in
// the final inhibit cycle.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic       timeoutErr
);

    localparam int          FW        = $clog2(FILTER_CYCLES + 1);
    localparam logic [12:0] INH_LAST  = 13'(INHIBIT_CYCLES - 1);
    localparam logic [12:0] INH_PRE   = 13'(INHIBIT_CYCLES - 2);
    localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    filt_q;
    logic [1:0]    filtPrev_q;
    logic [FW-1:0] filtCnt_q [2];

    state_t      state_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [3:0]  bitCnt_q;
    logic [12:0] inhCnt_q;
    logic [19:0] toCnt_q;
    logic        ackPend_q;
    logic        clkOe_q;
    logic        dataOe_q;
    logic        busy_q;
    logic        done_q;
    logic        ackErr_q;
    logic        timeoutErr_q;

    logic clkFilt;
    logic dataFilt;
    logic clkFall;
    logic timedState;

    assign clkFilt    = filt_q[0];
    assign dataFilt   = filt_q[1];
    assign clkFall    = filtPrev_q[0] & ~filt_q[0];
    assign timedState = (state_q == REQUEST) || (state_q == SHIFT) ||
                        (state_q == ACK)     || (state_q == WAIT_IDLE);

    // Both pad inputs are synchronised, then a line change is accepted only
    // after FILTER_CYCLES consecutive samples disagree with the filtered value,
    // so short glitches on the cable never look like device clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            filtPrev_q   <= 2'b11;
            filtCnt_q[0] <= '0;
            filtCnt_q[1] <= '0;
        end else begin
            sync1_q    <= {ps2DataIn, ps2ClkIn};
            sync2_q    <= sync1_q;
            filtPrev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    filtCnt_q[i] <= '0;
                end else if (filtCnt_q[i] == FILT_LAST) begin
                    filt_q[i]    <= sync2_q[i];
                    filtCnt_q[i] <= '0;
                end else begin
                    filtCnt_q[i] <= filtCnt_q[i] + FW'(1);
                end
            end
        end
    end

    // Frame sequencer. All line enables and status pulses are registered here.
    // The timeout check sits after the state case so that it overrides any
    // transition made in the same cycle, including a done in WAIT_IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bitCnt_q     <= '0;
            inhCnt_q     <= '0;
            toCnt_q      <= '0;
            ackPend_q    <= 1'b0;
            clkOe_q      <= 1'b0;
            dataOe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ackErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            ackErr_q     <= 1'b0;
            timeoutErr_q <= 1'b0;

            if (timedState && (toCnt_q != 20'hFFFFF)) begin
                toCnt_q <= toCnt_q + 20'd1;
            end

            case (state_q)
                IDLE: begin
                    if (txStart) begin
                        shift_q   <= txData;
                        parity_q  <= ~^txData;
                        bitCnt_q  <= '0;
                        toCnt_q   <= '0;
                        inhCnt_q  <= '0;
                        ackPend_q <= 1'b0;
                        busy_q    <= 1'b1;
                        clkOe_q   <= 1'b1;
                        dataOe_q  <= 1'b0;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    // The start bit goes out one cycle before the clock is
                    // released, so the data line is already low at release.
                    if (inhCnt_q == INH_LAST) begin
                        clkOe_q <= 1'b0;
                        state_q <= REQUEST;
                    end else begin
                        inhCnt_q <= inhCnt_q + 13'd1;
                        if (inhCnt_q == INH_PRE) begin
                            dataOe_q <= 1'b1;
                        end
                    end
                end
                REQUEST: begin
                    if (clkFall) begin
                        dataOe_q <= ~shift_q[0];
                        bitCnt_q <= 4'd1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // bitCnt counts bits already driven: 1..7 data, 8 parity,
                    // 9 means the stop bit (release) is next.
                    if (clkFall) begin
                        if (bitCnt_q <= 4'd7) begin
                            dataOe_q <= ~shift_q[bitCnt_q[2:0]];
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end else if (bitCnt_q == 4'd8) begin
                            dataOe_q <= ~parity_q;
                            bitCnt_q <= 4'd9;
                        end else begin
                            dataOe_q <= 1'b0;
                            state_q  <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (clkFall) begin
                        ackPend_q <= dataFilt;
                        state_q   <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clkFilt && dataFilt) begin
                        done_q   <= 1'b1;
                        ackErr_q <= ackPend_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    clkOe_q  <= 1'b0;
                    dataOe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase

            if (timedState && (toCnt_q == TO_LAST)) begin
                clkOe_q      <= 1'b0;
                dataOe_q     <= 1'b0;
                busy_q       <= 1'b0;
                done_q       <= 1'b0;
                ackErr_q     <= 1'b0;
                timeoutErr_q <= 1'b1;
                state_q      <= IDLE;
            end
        end
    end

    assign ps2ClkOe   = clkOe_q;
    assign ps2DataOe  = dataOe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ackErr     = ackErr_q;
    assign timeoutErr = timeoutErr_q;

endmodule
